// File: rtl/eq_seq_ctrl.sv
// ---------------------------------------------------------------------------
// eq_seq_ctrl
//   Sequential equality checker. Two WIDTH-bit operands are compared one
//   2-bit chunk per cycle, least significant chunk first, with a single
//   shared 2-bit equality slice. With EARLY_EXIT=1 the scan stops on the
//   first mismatching chunk; with EARLY_EXIT=0 every chunk is scanned, but
//   only the first mismatch is reported.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous reset, active low
//   start_valid   request valid; accepted when start_valid & start_ready
//   start_ready   controller idle, able to accept a request
//   a, b          operands, captured on accept
//   busy          comparison in progress
//   res_valid     result valid; held until res_ready
//   res_ready     consumer takes the result when res_valid & res_ready
//   res_eq        1 when a == b
//   mismatch_idx  index of the first mismatching chunk (0 when res_eq=1)
// ---------------------------------------------------------------------------
module eq_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1,
    localparam int IW        = ((WIDTH / 2) > 1) ? $clog2(WIDTH / 2) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_eq,
    output logic [IW-1:0]    mismatch_idx
);

    localparam int NCHUNK = WIDTH / 2;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    mm;
    logic             eq_acc;

    logic [1:0]       chunk_a;
    logic [1:0]       chunk_b;
    logic             chunk_eq;
    logic             first_mm;
    logic [IW-1:0]    mm_next;
    logic             last_step;

    // Chunk selection as an explicit mux over the chunk index, so that no
    // out-of-range part-select is ever formed (matters for WIDTH=2, where
    // idx is one bit wide but only value 0 is legal).
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            if (idx == IW'(c)) begin
                chunk_a = a_r[2*c +: 2];
                chunk_b = b_r[2*c +: 2];
            end
        end
    end

    // The shared 2-bit equality slice.
    assign chunk_eq = (chunk_a[0] ~^ chunk_b[0]) & (chunk_a[1] ~^ chunk_b[1]);

    // Only the first mismatch is remembered: once eq_acc has dropped,
    // later mismatching chunks leave mm untouched.
    assign first_mm  = eq_acc & ~chunk_eq;
    assign mm_next   = first_mm ? idx : mm;

    // Exit is decided before idx is incremented, so idx never wraps.
    assign last_step = (idx == LAST_IDX) || (EARLY_EXIT && !chunk_eq);

    // Controller FSM with all outputs registered. The result of the final
    // chunk is folded directly into res_eq/mismatch_idx on the RUN->DONE
    // edge so DONE presents a complete result immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            start_ready  <= 1'b1;
            busy         <= 1'b0;
            res_valid    <= 1'b0;
            res_eq       <= 1'b0;
            mismatch_idx <= '0;
            a_r          <= '0;
            b_r          <= '0;
            idx          <= '0;
            mm           <= '0;
            eq_acc       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_r         <= a;
                        b_r         <= b;
                        idx         <= '0;
                        mm          <= '0;
                        eq_acc      <= 1'b1;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    eq_acc <= eq_acc & chunk_eq;
                    mm     <= mm_next;
                    if (last_step) begin
                        busy         <= 1'b0;
                        res_valid    <= 1'b1;
                        res_eq       <= eq_acc & chunk_eq;
                        mismatch_idx <= mm_next;
                        state        <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_eq_seq_ctrl
//   Bench for eq_seq_ctrl. Three instances share the clock and reset:
//   WIDTH=8 with early exit, WIDTH=8 with full scan (these two also share
//   their inputs), and WIDTH=2. Expected results and latencies come from a
//   chunk-by-chunk reference function written from the behavioural rules.
// ---------------------------------------------------------------------------
module tb_eq_seq_ctrl;

    logic       clk;
    logic       rst_n;

    logic       sv8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       rr8;

    logic       sr_e, busy_e, rv_e, eq_e;
    logic [1:0] idx_e;
    logic       sr_f, busy_f, rv_f, eq_f;
    logic [1:0] idx_f;

    logic       sv2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       rr2;
    logic       sr2, busy2, rv2, eq2;
    logic [0:0] idx2;

    int checks;
    int failures;

    eq_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv8), .start_ready(sr_e),
        .a(a8), .b(b8),
        .busy(busy_e), .res_valid(rv_e), .res_ready(rr8),
        .res_eq(eq_e), .mismatch_idx(idx_e)
    );

    eq_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv8), .start_ready(sr_f),
        .a(a8), .b(b8),
        .busy(busy_f), .res_valid(rv_f), .res_ready(rr8),
        .res_eq(eq_f), .mismatch_idx(idx_f)
    );

    eq_seq_ctrl #(.WIDTH(2), .EARLY_EXIT(1'b1)) dut_2 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv2), .start_ready(sr2),
        .a(a2), .b(b2),
        .busy(busy2), .res_valid(rv2), .res_ready(rr2),
        .res_eq(eq2), .mismatch_idx(idx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: walk the chunks LSB first. Equality is a==b; the reported
    // index is the first differing chunk; latency is the number of chunks
    // examined (first mismatch + 1 when exiting early, else all chunks).
    function automatic void model(input int unsigned x, input int unsigned y,
                                  input int nchunk, input bit early,
                                  output bit eq, output int mi, output int lat);
        eq  = 1'b1;
        mi  = 0;
        lat = nchunk;
        for (int c = 0; c < nchunk; c++) begin
            if (((x >> (2 * c)) & 3) != ((y >> (2 * c)) & 3)) begin
                if (eq) begin
                    mi = c;
                    if (early) lat = c + 1;
                end
                eq = 1'b0;
            end
        end
    endfunction

    // One WIDTH=8 transaction on both 8-bit instances with res_ready held
    // high; latency counted in rising edges after the accept edge.
    task automatic run8(input logic [7:0] va, input logic [7:0] vb);
        bit x_eq_e, x_eq_f, got_e, got_f;
        int x_mi_e, x_mi_f, x_lat_e, x_lat_f;
        model(32'(va), 32'(vb), 4, 1'b1, x_eq_e, x_mi_e, x_lat_e);
        model(32'(va), 32'(vb), 4, 1'b0, x_eq_f, x_mi_f, x_lat_f);
        @(negedge clk);
        rr8 = 1'b1;
        checks++;
        if (sr_e !== 1'b1 || sr_f !== 1'b1) begin
            failures++;
            $display("[TB] FAIL run8_ready a=%h b=%h: start_ready e=%b f=%b, required 1/1", va, vb, sr_e, sr_f);
        end
        sv8 = 1'b1;
        a8  = va;
        b8  = vb;
        @(negedge clk);
        sv8 = 1'b0;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        checks++;
        if (busy_e !== 1'b1 || busy_f !== 1'b1) begin
            failures++;
            $display("[TB] FAIL run8_busy a=%h b=%h: busy e=%b f=%b, required 1/1", va, vb, busy_e, busy_f);
        end
        got_e = 1'b0;
        got_f = 1'b0;
        for (int cyc = 1; cyc <= 12 && !(got_e && got_f); cyc++) begin
            @(negedge clk);
            if (rv_e === 1'b1 && !got_e) begin
                got_e = 1'b1;
                checks++;
                if (cyc != x_lat_e || eq_e !== x_eq_e || idx_e !== x_mi_e[1:0]) begin
                    failures++;
                    $display("[TB] FAIL run8_early a=%h b=%h: lat=%0d eq=%b idx=%0d, required lat=%0d eq=%b idx=%0d",
                             va, vb, cyc, eq_e, idx_e, x_lat_e, x_eq_e, x_mi_e);
                end
            end
            if (rv_f === 1'b1 && !got_f) begin
                got_f = 1'b1;
                checks++;
                if (cyc != x_lat_f || eq_f !== x_eq_f || idx_f !== x_mi_f[1:0]) begin
                    failures++;
                    $display("[TB] FAIL run8_full a=%h b=%h: lat=%0d eq=%b idx=%0d, required lat=%0d eq=%b idx=%0d",
                             va, vb, cyc, eq_f, idx_f, x_lat_f, x_eq_f, x_mi_f);
                end
            end
        end
        if (!got_e || !got_f) begin
            checks++;
            failures++;
            $display("[TB] FAIL run8_timeout a=%h b=%h: got e=%b f=%b, required 1/1", va, vb, got_e, got_f);
        end
    endtask

    task automatic run2(input logic [1:0] va, input logic [1:0] vb);
        bit x_eq, got;
        int x_mi, x_lat;
        model(32'(va), 32'(vb), 1, 1'b1, x_eq, x_mi, x_lat);
        @(negedge clk);
        rr2 = 1'b1;
        checks++;
        if (sr2 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL run2_ready a=%b b=%b: start_ready=%b, required 1", va, vb, sr2);
        end
        sv2 = 1'b1;
        a2  = va;
        b2  = vb;
        @(negedge clk);
        sv2 = 1'b0;
        a2  = 2'($urandom);
        b2  = 2'($urandom);
        got = 1'b0;
        for (int cyc = 1; cyc <= 6 && !got; cyc++) begin
            @(negedge clk);
            if (rv2 === 1'b1) begin
                got = 1'b1;
                checks++;
                if (cyc != x_lat || eq2 !== x_eq || idx2 !== x_mi[0:0]) begin
                    failures++;
                    $display("[TB] FAIL run2 a=%b b=%b: lat=%0d eq=%b idx=%0d, required lat=%0d eq=%b idx=%0d",
                             va, vb, cyc, eq2, idx2, x_lat, x_eq, x_mi);
                end
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL run2_timeout a=%b b=%b: no res_valid, required within 6 cycles", va, vb);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sv8 = 1'b0; a8 = '0; b8 = '0; rr8 = 1'b0;
        sv2 = 1'b0; a2 = '0; b2 = '0; rr2 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sr_e !== 1'b1 || busy_e !== 1'b0 || rv_e !== 1'b0 || eq_e !== 1'b0 || idx_e !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_early: sr=%b busy=%b rv=%b eq=%b idx=%0d, required 1 0 0 0 0",
                     sr_e, busy_e, rv_e, eq_e, idx_e);
        end
        checks++;
        if (sr_f !== 1'b1 || busy_f !== 1'b0 || rv_f !== 1'b0 || eq_f !== 1'b0 || idx_f !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_full: sr=%b busy=%b rv=%b eq=%b idx=%0d, required 1 0 0 0 0",
                     sr_f, busy_f, rv_f, eq_f, idx_f);
        end
        checks++;
        if (sr2 !== 1'b1 || busy2 !== 1'b0 || rv2 !== 1'b0 || eq2 !== 1'b0 || idx2 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_w2: sr=%b busy=%b rv=%b eq=%b idx=%0d, required 1 0 0 0 0",
                     sr2, busy2, rv2, eq2, idx2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run8(8'hA5, 8'hA5);
        run8(8'h00, 8'h04);
        run8(8'h0F, 8'hF0);
        run8(8'h00, 8'hC0);
        run2(2'b10, 2'b10);
        run2(2'b10, 2'b11);
    endtask

    // Result held in DONE while res_ready is low; new requests pushed at
    // the controller during RUN/DONE must not be taken.
    task automatic test_hold();
        bit got_e, got_f;
        @(negedge clk);
        rr8 = 1'b0;
        sv8 = 1'b1;
        a8  = 8'h00;
        b8  = 8'h04;
        got_e = 1'b0;
        got_f = 1'b0;
        for (int cyc = 1; cyc <= 12 && !(got_e && got_f); cyc++) begin
            @(negedge clk);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if (rv_e === 1'b1) got_e = 1'b1;
            if (rv_f === 1'b1) got_f = 1'b1;
        end
        checks++;
        if (!got_e || !got_f) begin
            failures++;
            $display("[TB] FAIL hold_reach_done: rv e=%b f=%b, required 1/1", got_e, got_f);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            checks++;
            if (rv_e !== 1'b1 || eq_e !== 1'b0 || idx_e !== 2'd1 || sr_e !== 1'b0 ||
                rv_f !== 1'b1 || eq_f !== 1'b0 || idx_f !== 2'd1 || sr_f !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_stable cyc%0d: e rv=%b eq=%b idx=%0d sr=%b f rv=%b eq=%b idx=%0d sr=%b, required rv=1 eq=0 idx=1 sr=0",
                         i, rv_e, eq_e, idx_e, sr_e, rv_f, eq_f, idx_f, sr_f);
            end
        end
        sv8 = 1'b0;
        rr8 = 1'b1;
        @(negedge clk);
        checks++;
        if (rv_e !== 1'b0 || rv_f !== 1'b0 || sr_e !== 1'b1 || sr_f !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_release: rv e=%b f=%b sr e=%b f=%b, required rv=0 sr=1",
                     rv_e, rv_f, sr_e, sr_f);
        end
        @(negedge clk);
        checks++;
        if (busy_e !== 1'b0 || busy_f !== 1'b0 || sr_e !== 1'b1 || sr_f !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_no_queue: busy e=%b f=%b sr e=%b f=%b, required busy=0 sr=1",
                     busy_e, busy_f, sr_e, sr_f);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        @(negedge clk);
        rr8 = 1'b1;
        sv8 = 1'b1;
        a8  = 8'h12;
        b8  = 8'h12;
        @(negedge clk);
        sv8 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (sr_e !== 1'b1 || rv_e !== 1'b0 || busy_e !== 1'b0 ||
            sr_f !== 1'b1 || rv_f !== 1'b0 || busy_f !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_run: e sr=%b rv=%b busy=%b f sr=%b rv=%b busy=%b, required sr=1 rv=0 busy=0",
                     sr_e, rv_e, busy_e, sr_f, rv_f, busy_f);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rv_e === 1'b1 || rv_f === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("[TB] FAIL reset_drops_result: res_valid seen=%b, required 0", seen);
        end
        run8(8'h3C, 8'h3C);
    endtask

    task automatic test_random();
        logic [7:0] va, vb;
        int c;
        for (int n = 0; n < 40; n++) begin
            va = 8'($urandom);
            case ($urandom_range(0, 2))
                0: vb = va;
                1: begin
                    c  = $urandom_range(0, 3);
                    vb = va ^ (8'($urandom_range(1, 3)) << (2 * c));
                end
                default: vb = 8'($urandom);
            endcase
            run8(va, vb);
        end
        for (int n = 0; n < 10; n++) begin
            run2(2'($urandom), 2'($urandom));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
